mod_reconstruct: RTL and testbench

//  Multi-cycle shift-add unit computing result = q*b + r: the inverse of the mod/divide unit.

---
 rtl/mod_pkg.sv | 26 ++
 rtl/mod_reconstruct_cu.sv | 71 +++++++
 rtl/mod_reconstruct_dp.sv | 81 ++++++++
 rtl/mod_reconstruct.sv | 68 ++++++
 tb/tb_mod_reconstruct.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mod_pkg.sv
// ---------------------------------------------------------------------------
// mod_pkg
//   Shared definitions for the mod / reconstruct arithmetic blocks:
//   FSM state encoding, default operand width and counter-width helper.
//   Optional feature macro used by the blocks importing this package:
//     MOD_RECON_CHECK_EN
// ---------------------------------------------------------------------------
package mod_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Width of the RUN-cycle counter; never narrower than one bit.
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W_DEF = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/mod_reconstruct_cu.sv
// ---------------------------------------------------------------------------
// mod_reconstruct_cu
//   Control unit of the shift-add reconstruct block: IDLE/LOAD/RUN/DONE FSM,
//   RUN-cycle counter and the busy / done outputs.
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous, active-low
//     start  in   request, sampled only in IDLE
//     last   in   counter has reached WIDTH-1 (computed by the top level)
//     state  out  current FSM state (encoding from mod_pkg)
//     cnt    out  RUN-cycle counter
//     busy   out  high in LOAD and RUN
//     done   out  one-cycle pulse, aligned with the result register update
//   Macro: MOD_RECON_CHECK_EN has no effect on this unit.
// ---------------------------------------------------------------------------
module mod_reconstruct_cu
   import mod_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   localparam int CNT_W = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             last,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             done
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         // done is registered on the DONE cycle, the same edge that loads
         // the result register, so done and a valid result appear together.
         r_done  <= (r_state == ST_DONE);
         case (r_state)
            ST_LOAD: r_cnt <= '0;
            ST_RUN:  r_cnt <= r_cnt + CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (start) w_next = ST_LOAD;
         ST_LOAD: w_next = ST_RUN;
         ST_RUN:  if (last) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   assign state = r_state;
   assign cnt   = r_cnt;
   assign busy  = (r_state == ST_LOAD) || (r_state == ST_RUN);
   assign done  = r_done;

endmodule

// File: rtl/mod_reconstruct_dp.sv
// ---------------------------------------------------------------------------
// mod_reconstruct_dp
//   Datapath of the reconstruct block: shift-add multiplier with the
//   accumulator preloaded with the addend, so acc ends at q*b + r.
//   Ports:
//     clk     in   clock, rising edge
//     reset   in   asynchronous, active-low
//     state   in   FSM state from the control unit
//     q, b, r in   quotient, divisor, remainder (latched in LOAD)
//     result  out  2*WIDTH-bit q*b + r, loaded in DONE, held until next LOAD
//     err     out  invalid mod triple flag
//   Macro MOD_RECON_CHECK_EN: when defined, LOAD registers
//   err = (b == 0) || (r >= b); otherwise err is tied 0.
// ---------------------------------------------------------------------------
module mod_reconstruct_dp
   import mod_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         state,
   input  logic [WIDTH-1:0]   q,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   r,
   output logic [2*WIDTH-1:0] result,
   output logic               err
);

   state_t             w_state;
   logic [WIDTH-1:0]   r_mq;
   logic [2*WIDTH-1:0] r_mb;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_result;

   assign w_state = state_t'(state);

   // acc cannot overflow: (2^W-1)^2 + (2^W-1) < 2^(2W).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mq     <= '0;
         r_mb     <= '0;
         r_acc    <= '0;
         r_result <= '0;
      end else begin
         case (w_state)
            ST_LOAD: begin
               r_mq  <= q;
               r_mb  <= {{WIDTH{1'b0}}, b};
               r_acc <= {{WIDTH{1'b0}}, r};
            end
            ST_RUN: begin
               if (r_mq[0]) r_acc <= r_acc + r_mb;
               r_mb <= r_mb << 1;
               r_mq <= r_mq >> 1;
            end
            ST_DONE: r_result <= r_acc;
            default: ;
         endcase
      end
   end

   assign result = r_result;

`ifdef MOD_RECON_CHECK_EN
   logic r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err <= 1'b0;
      end else if (w_state == ST_LOAD) begin
         r_err <= (b == '0) || (r >= b);
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: rtl/mod_reconstruct.sv
// ---------------------------------------------------------------------------
// mod_reconstruct
//   Multi-cycle shift-add unit computing result = q*b + r, the inverse of the
//   mod/divide unit. Rebuilds a dividend from quotient, divisor, remainder.
//   Latency: start sampled in IDLE at edge N -> done high after edge N+WIDTH+2.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   asynchronous, active-low; clears all state
//     start      in   request, sampled only in IDLE (no queueing)
//     q, b, r    in   quotient, divisor, remainder
//     busy       out  high in LOAD and RUN
//     done       out  one-cycle pulse when result becomes valid
//     result     out  q*b + r, held until the next LOAD
//     err        out  invalid mod triple (only with MOD_RECON_CHECK_EN)
//     dbg_state  out  current FSM state (mod_pkg::state_t encoding)
//   Macro: MOD_RECON_CHECK_EN enables the err check; default build ties err 0.
// ---------------------------------------------------------------------------
module mod_reconstruct
   import mod_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   q,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   r,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic               err,
   output logic [1:0]         dbg_state
);

   localparam int CNT_W = cnt_w(WIDTH);

   logic [1:0]       w_state;
   logic [CNT_W-1:0] w_cnt;
   logic             w_last;

   assign w_last = (w_cnt == CNT_W'(WIDTH - 1));

   mod_reconstruct_cu #(.WIDTH(WIDTH)) u_cu (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .last  (w_last),
      .state (w_state),
      .cnt   (w_cnt),
      .busy  (busy),
      .done  (done)
   );

   mod_reconstruct_dp #(.WIDTH(WIDTH)) u_dp (
      .clk    (clk),
      .reset  (reset),
      .state  (w_state),
      .q      (q),
      .b      (b),
      .r      (r),
      .result (result),
      .err    (err)
   );

   assign dbg_state = w_state;

endmodule

// File: tb/tb_mod_reconstruct.sv
// ---------------------------------------------------------------------------
// tb_mod_reconstruct
//   Directed table of {q, b, r, expected result, expected err} records plus
//   hand-written sequences for async reset mid-RUN and back-to-back starts.
// ---------------------------------------------------------------------------
module tb_mod_reconstruct;

   localparam int W = 32;

   logic           clk;
   logic           reset;
   logic           start;
   logic [W-1:0]   q, b, r;
   logic           busy, done, err;
   logic [2*W-1:0] result;
   logic [1:0]     dbg_state;

   int n_vec  = 0;
   int n_miss = 0;

   mod_reconstruct #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .q         (q),
      .b         (b),
      .r         (r),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   q;
      logic [W-1:0]   b;
      logic [W-1:0]   r;
      logic [2*W-1:0] res;
      logic           bad;   // invalid mod triple: b==0 or r>=b
   } vec_t;

   vec_t tv[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Launch one op and wait (bounded) for done; lat counts edges after the
   // start-sampling edge, so lat==W+2 is the nominal latency.
   task automatic run_op(input logic [W-1:0] iq, input logic [W-1:0] ib, input logic [W-1:0] ir,
                         output logic [2*W-1:0] res, output logic e,
                         output int lat, output int bcnt);
      @(negedge clk);
      q = iq; b = ib; r = ir; start = 1'b1;
      lat = -1; bcnt = 0; res = '0; e = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 0) start = 1'b0;
         if (busy) bcnt++;
         if (done) begin
            lat = k; res = result; e = err;
            break;
         end
      end
   endtask

   initial begin
      logic [2*W-1:0] res, res1, res2;
      logic           e, exp_err;
      int             lat, bcnt, k1, k2, npulse;

      tv[0] = '{32'd5,         32'd7,         32'd3,         64'd38,                  1'b0};
      tv[1] = '{32'd0,         32'd9,         32'd4,         64'd4,                   1'b0};
      tv[2] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFF00000000,    1'b1};
      tv[3] = '{32'd142,       32'd7,         32'd6,         64'd1000,                1'b0};
      tv[4] = '{32'd1,         32'd4,         32'd4,         64'd8,                   1'b1};
      tv[5] = '{32'd1,         32'd4,         32'd3,         64'd7,                   1'b0};
      tv[6] = '{32'd9,         32'd0,         32'd5,         64'd5,                   1'b1};
      tv[7] = '{32'd3,         32'd10,        32'd2,         64'd32,                  1'b0};
      tv[8] = '{32'h12345678,  32'h10,        32'h5,         64'h123456785,           1'b0};
      tv[9] = '{32'h80000000,  32'd2,         32'd1,         64'h100000001,           1'b0};

      // reset
      reset = 1'b0; start = 1'b0; q = '0; b = '0; r = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",   64'(busy),      64'd0);
      check("rst_done",   64'(done),      64'd0);
      check("rst_result", result,         64'd0);
      check("rst_err",    64'(err),       64'd0);
      check("rst_state",  64'(dbg_state), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // table
      foreach (tv[i]) begin
`ifdef MOD_RECON_CHECK_EN
         exp_err = tv[i].bad;
`else
         exp_err = 1'b0;
`endif
         run_op(tv[i].q, tv[i].b, tv[i].r, res, e, lat, bcnt);
         check($sformatf("v%0d_result", i), res,        tv[i].res);
         check($sformatf("v%0d_err", i),    64'(e),     64'(exp_err));
         check($sformatf("v%0d_latency", i), 64'(lat),  64'd34);
         check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd33);
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
         check($sformatf("v%0d_result_hold", i), result,   tv[i].res);
      end

      // async reset in the middle of RUN: abandon op, clear at once
      @(negedge clk);
      q = 32'd5; b = 32'd7; r = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      check("midrun_state", 64'(dbg_state), 64'd2);
      #3 reset = 1'b0;
      #1;
      check("midrun_rst_busy",   64'(busy),      64'd0);
      check("midrun_rst_result", result,         64'd0);
      check("midrun_rst_done",   64'(done),      64'd0);
      check("midrun_rst_state",  64'(dbg_state), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      npulse = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done) npulse++;
      end
      check("midrun_no_done",    64'(npulse), 64'd0);
      check("midrun_result_low", result,      64'd0);

      // start held high: back-to-back ops, q changed mid-RUN of the first
      @(negedge clk);
      q = 32'd5; b = 32'd7; r = 32'd3; start = 1'b1;
      k1 = -1; k2 = -1; res1 = '0; res2 = '0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 10) q = 32'd2;
         if (done) begin
            if (k1 < 0) begin
               k1 = k; res1 = result;
            end else begin
               k2 = k; res2 = result; start = 1'b0;
               break;
            end
         end
      end
      check("b2b_first_latency", 64'(k1),      64'd34);
      check("b2b_interval",      64'(k2 - k1), 64'd35);
      check("b2b_first_result",  res1,         64'd38);
      check("b2b_second_result", res2,         64'd17);
      repeat (3) @(negedge clk);
      check("b2b_idle_busy",     64'(busy),    64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
